adder_nbit_seq: RTL



---
 rtl/adder_seq_pkg.sv | 15 +
 rtl/adder_slice.sv | 14 +
 rtl/adder_nbit_seq.sv | 111 +++++++++++
 3 files changed

// File: rtl/adder_seq_pkg.sv
// Shared types and helpers for the sequential N-bit adder/subtractor.
package adder_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Slice-index width; never narrower than one bit.
   function automatic int idx_w(input int nchunk);
      return (nchunk > 1) ? $clog2(nchunk) : 1;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple slice with carry in/out.
module adder_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);

   assign {cout, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder_nbit_seq.sv
// Multi-cycle N-bit adder/subtractor, CHUNK bits per clock, LSB slice first,
// with valid/ready handshakes and registered carry/borrow/overflow.
module adder_nbit_seq #(
   parameter int N     = 8,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N:0]   sum,
   output logic         overflow
);
   import adder_seq_pkg::*;

   localparam int NCHUNK = N / CHUNK;
   localparam int IW     = idx_w(NCHUNK);

   if (N < 1 || CHUNK < 1 || (N % CHUNK) != 0) begin : g_bad
      $error("adder_nbit_seq: CHUNK must divide N");
   end

   state_t         state;
   state_t         nxt;
   logic [N-1:0]   a_r;
   logic [N-1:0]   b_r;
   logic [N-1:0]   acc;
   logic [N-1:0]   res;
   logic           sub_r;
   logic           cy;
   logic [IW-1:0]  idx;
   logic [CHUNK-1:0] xs;
   logic [CHUNK-1:0] ys;
   logic [CHUNK-1:0] s;
   logic           c;
   logic           last;
   logic           accept;

   assign in_ready  = rst_n & ((state == IDLE) |
                               ((state == DONE) & out_ready));
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;
   assign last      = (idx == IW'(NCHUNK - 1));

   always_comb begin
      xs = a_r[int'(idx)*CHUNK +: CHUNK];
      ys = b_r[int'(idx)*CHUNK +: CHUNK];
   end

   adder_slice #(.W(CHUNK)) u_slice (
      .x    (xs),
      .y    (ys),
      .cin  (cy),
      .s    (s),
      .cout (c)
   );

   // Working copy with the current slice merged in; sum only sees it at the end.
   always_comb begin
      res = acc;
      res[int'(idx)*CHUNK +: CHUNK] = s;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (accept) nxt = RUN;
         RUN:     if (last)   nxt = DONE;
         DONE:    if (out_ready) nxt = in_valid ? RUN : IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_r      <= '0;
         b_r      <= '0;
         acc      <= '0;
         sub_r    <= 1'b0;
         cy       <= 1'b0;
         idx      <= '0;
         sum      <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         a_r   <= a;
         b_r   <= b ^ {N{sub}};
         sub_r <= sub;
         cy    <= sub;
         idx   <= '0;
      end else if (state == RUN) begin
         acc <= res;
         cy  <= c;
         idx <= last ? '0 : idx + IW'(1);
         if (last) begin
            sum      <= {sub_r ? ~c : c, res};
            overflow <= (a_r[N-1] == b_r[N-1]) & (res[N-1] != a_r[N-1]);
         end
      end
   end

endmodule
